if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined processor.
- Owns the program counter and drives the address and read strobe of the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register.
- Handles stall from hazard detection, branch/jump redirect with bubble insertion, and a halt state.

---
 rtl/if_fetch_stage.sv | 105 ++++++++++
 tb/tb_if_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and loads the IF/ID pipeline register; handles stall, redirect and halt.
module if_fetch_stage #(
   parameter int unsigned          PC_W       = 4,
   parameter int unsigned          INSTR_W    = 32,
   parameter logic [INSTR_W-1:0]   NOP_INSTR  = '0,
   parameter logic [INSTR_W-1:0]   HALT_INSTR = '1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_i,
   input  logic               branch_taken_i,
   input  logic [PC_W-1:0]    branch_target_i,
   input  logic               jump_i,
   input  logic [PC_W-1:0]    jump_target_i,
   output logic [PC_W-1:0]    imem_addr_o,
   output logic               imem_read_o,
   input  logic [INSTR_W-1:0] imem_data_i,
   output logic [INSTR_W-1:0] ifid_instr_o,
   output logic [PC_W-1:0]    ifid_pc_o,
   output logic [PC_W-1:0]    ifid_pc_plus1_o,
   output logic               ifid_valid_o,
   output logic               halted_o
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
   logic [PC_W-1:0]    ifid_pc1_q, ifid_pc1_d;
   logic               valid_q, valid_d;

   logic               redirect;
   logic [PC_W-1:0]    target;
   logic [PC_W-1:0]    pc_inc;

   assign redirect = jump_i | branch_taken_i;
   assign target   = jump_i ? jump_target_i : branch_target_i;
   assign pc_inc   = pc_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_BOOT;
         pc_q       <= '0;
         instr_q    <= NOP_INSTR;
         ifid_pc_q  <= '0;
         ifid_pc1_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         ifid_pc_q  <= ifid_pc_d;
         ifid_pc1_q <= ifid_pc1_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      ifid_pc_d  = ifid_pc_q;
      ifid_pc1_d = ifid_pc1_q;
      valid_d    = valid_q;

      // A redirect behaves identically in every state and outranks stall.
      if (redirect) begin
         pc_d       = target;
         instr_d    = NOP_INSTR;
         ifid_pc_d  = '0;
         ifid_pc1_d = '0;
         valid_d    = 1'b0;
         state_d    = S_RUN;
      end else begin
         case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
               if (!stall_i) begin
                  instr_d    = imem_data_i;
                  ifid_pc_d  = pc_q;
                  ifid_pc1_d = pc_inc;
                  valid_d    = 1'b1;
                  if (imem_data_i == HALT_INSTR) state_d = S_HALT;
                  else                           pc_d    = pc_inc;
               end
            end
            // The halt word keeps valid for its entry cycle only.
            S_HALT:  valid_d = 1'b0;
            default: state_d = S_BOOT;
         endcase
      end
   end

   assign imem_addr_o     = pc_q;
   assign imem_read_o     = (state_q != S_HALT);
   assign ifid_instr_o    = instr_q;
   assign ifid_pc_o       = ifid_pc_q;
   assign ifid_pc_plus1_o = ifid_pc1_q;
   assign ifid_valid_o    = valid_q;
   assign halted_o        = (state_q == S_HALT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: expected observations are queued with
// each cycle's stimulus and popped for comparison one clock later.
module tb_if_fetch_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [3:0]  pc;
      logic [3:0]  pc1;
      logic        valid;
      logic [3:0]  addr;
      logic        halted;
      logic        read;
   } obs_t;

   typedef struct packed {
      logic       stall;
      logic       br;
      logic [3:0] bt;
      logic       j;
      logic [3:0] jt;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_i = 1'b0;
   logic        branch_taken_i = 1'b0;
   logic [3:0]  branch_target_i = '0;
   logic        jump_i = 1'b0;
   logic [3:0]  jump_target_i = '0;
   logic [3:0]  imem_addr_o;
   logic        imem_read_o;
   logic [31:0] imem_data_i;
   logic [31:0] ifid_instr_o;
   logic [3:0]  ifid_pc_o;
   logic [3:0]  ifid_pc_plus1_o;
   logic        ifid_valid_o;
   logic        halted_o;

   logic [31:0] mem [16];
   obs_t        sb [$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

   if_fetch_stage #(
      .PC_W      (4),
      .INSTR_W   (32),
      .NOP_INSTR (32'h0000_0000),
      .HALT_INSTR(32'hFFFF_FFFF)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_i        (stall_i),
      .branch_taken_i (branch_taken_i),
      .branch_target_i(branch_target_i),
      .jump_i         (jump_i),
      .jump_target_i  (jump_target_i),
      .imem_addr_o    (imem_addr_o),
      .imem_read_o    (imem_read_o),
      .imem_data_i    (imem_data_i),
      .ifid_instr_o   (ifid_instr_o),
      .ifid_pc_o      (ifid_pc_o),
      .ifid_pc_plus1_o(ifid_pc_plus1_o),
      .ifid_valid_o   (ifid_valid_o),
      .halted_o       (halted_o)
   );

   always #5 clk = ~clk;
   assign imem_data_i = mem[imem_addr_o];

   function automatic obs_t mk(logic [31:0] instr, logic [3:0] pc, logic [3:0] pc1,
                               logic valid, logic [3:0] addr, logic halted, logic read);
      mk = '{instr: instr, pc: pc, pc1: pc1, valid: valid, addr: addr,
             halted: halted, read: read};
   endfunction

   function automatic obs_t sample();
      sample = mk(ifid_instr_o, ifid_pc_o, ifid_pc_plus1_o, ifid_valid_o,
                  imem_addr_o, halted_o, imem_read_o);
   endfunction

   function automatic stim_t st(logic stall, logic br, logic [3:0] bt, logic j, logic [3:0] jt);
      st = '{stall: stall, br: br, bt: bt, j: j, jt: jt};
   endfunction

   task automatic drive(stim_t s);
      stall_i         = s.stall;
      branch_taken_i  = s.br;
      branch_target_i = s.bt;
      jump_i          = s.j;
      jump_target_i   = s.jt;
   endtask

   function automatic logic [31:0] word(int unsigned a);
      word = 32'hA000_0000 + a;
   endfunction

   task automatic test_reset();
      obs_t e, got;
      rst_n = 1'b0;
      drive(st(0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(mk(32'h0, 0, 0, 0, 0, 0, 1));
      e   = sb.pop_front();
      got = sample();
      n_vec++;
      if (got !== e) begin
         n_err++;
         $display("FAIL reset: got %h expected %h", got, e);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fetch();
      stim_t s [$];
      obs_t  x [$];
      obs_t  e, got;
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(32'h0,   0, 0, 0, 0, 0, 1));
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(word(0), 0, 1, 1, 1, 0, 1));
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(word(1), 1, 2, 1, 2, 0, 1));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(x[i]);
         @(posedge clk);
         #1;
         e   = sb.pop_front();
         got = sample();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL fetch[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_stall();
      stim_t s [$];
      obs_t  x [$];
      obs_t  e, got;
      s.push_back(st(1, 0, 0, 0, 0)); x.push_back(mk(word(1), 1, 2, 1, 2, 0, 1));
      s.push_back(st(1, 0, 0, 0, 0)); x.push_back(mk(word(1), 1, 2, 1, 2, 0, 1));
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(word(2), 2, 3, 1, 3, 0, 1));
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(word(3), 3, 4, 1, 4, 0, 1));
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(word(4), 4, 5, 1, 5, 0, 1));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(x[i]);
         @(posedge clk);
         #1;
         e   = sb.pop_front();
         got = sample();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL stall[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_redirect();
      stim_t s [$];
      obs_t  x [$];
      obs_t  e, got;
      // branch at PC=5, then jump+branch+stall together (jump wins, stall ignored)
      s.push_back(st(0, 1, 9, 0, 0)); x.push_back(mk(32'h0,   0, 0,  0, 9,  0, 1));
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(word(9), 9, 10, 1, 10, 0, 1));
      s.push_back(st(1, 1, 7, 1, 3)); x.push_back(mk(32'h0,   0, 0,  0, 3,  0, 1));
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(word(3), 3, 4,  1, 4,  0, 1));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(x[i]);
         @(posedge clk);
         #1;
         e   = sb.pop_front();
         got = sample();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL redirect[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_wrap();
      stim_t s [$];
      obs_t  x [$];
      obs_t  e, got;
      s.push_back(st(0, 0, 0, 1, 14)); x.push_back(mk(32'h0,    0,  0,  0, 14, 0, 1));
      s.push_back(st(0, 0, 0, 0, 0));  x.push_back(mk(word(14), 14, 15, 1, 15, 0, 1));
      s.push_back(st(0, 0, 0, 0, 0));  x.push_back(mk(word(15), 15, 0,  1, 0,  0, 1));
      s.push_back(st(0, 0, 0, 0, 0));  x.push_back(mk(word(0),  0,  1,  1, 1,  0, 1));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(x[i]);
         @(posedge clk);
         #1;
         e   = sb.pop_front();
         got = sample();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL wrap[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_halt();
      stim_t s [$];
      obs_t  x [$];
      obs_t  e, got;
      mem[4] = HALTW;
      s.push_back(st(0, 0, 0, 1, 3)); x.push_back(mk(32'h0,   0, 0, 0, 3, 0, 1));
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(word(3), 3, 4, 1, 4, 0, 1));
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(HALTW,   4, 5, 1, 4, 1, 0));
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(HALTW,   4, 5, 0, 4, 1, 0));
      s.push_back(st(1, 0, 0, 0, 0)); x.push_back(mk(HALTW,   4, 5, 0, 4, 1, 0));
      s.push_back(st(0, 0, 0, 1, 0)); x.push_back(mk(32'h0,   0, 0, 0, 0, 0, 1));
      s.push_back(st(0, 0, 0, 0, 0)); x.push_back(mk(word(0), 0, 1, 1, 1, 0, 1));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]);
         sb.push_back(x[i]);
         @(posedge clk);
         #1;
         e   = sb.pop_front();
         got = sample();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL halt[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_async_reset();
      obs_t e, got;
      drive(st(0, 0, 0, 0, 0));
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      sb.push_back(mk(32'h0, 0, 0, 0, 0, 0, 1));
      e   = sb.pop_front();
      got = sample();
      n_vec++;
      if (got !== e) begin
         n_err++;
         $display("FAIL async_reset: got %h expected %h", got, e);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = word(i);
      test_reset();
      test_fetch();
      test_stall();
      test_redirect();
      test_wrap();
      test_halt();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
